// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the data-side and instruction-side memory bridges.
//   MEM_BYTE / MEM_HALF / MEM_WORD : access size codes carried in mem_op[1:0]
//   MEM_UNSIGNED_BIT               : bit of mem_op selecting zero-extension
//   db_state_e                     : data bridge handshake state encoding
// ---------------------------------------------------------------------------
package mem_pkg;

    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;

    localparam int MEM_UNSIGNED_BIT = 2;

    typedef enum logic [1:0] {
        DB_IDLE = 2'b00,
        DB_ADDR = 2'b01,
        DB_DATA = 2'b10,
        DB_HOLD = 2'b11
    } db_state_e;

endpackage

// File: rtl/dmem_sram_bridge_if.sv
// ---------------------------------------------------------------------------
// dmem_sram_bridge_if
// SRAM-like request/response bus between the data bridge (master) and the
// memory system (slave).
//   data_req / data_wr / data_size / data_addr / data_wstrb / data_wdata :
//       request channel, driven by the master
//   data_addr_ok : slave accepted the request this cycle
//   data_data_ok : response/completion this cycle
//   data_rdata   : read data, valid with data_data_ok
// ---------------------------------------------------------------------------
interface dmem_sram_bridge_if #(
    parameter int AW = 32,
    parameter int DW = 32
);

    logic          data_req;
    logic          data_wr;
    logic [1:0]    data_size;
    logic [AW-1:0] data_addr;
    logic [3:0]    data_wstrb;
    logic [DW-1:0] data_wdata;
    logic          data_addr_ok;
    logic          data_data_ok;
    logic [DW-1:0] data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );

endinterface

// File: rtl/store_lane_gen.sv
// ---------------------------------------------------------------------------
// store_lane_gen
// Pure combinational byte-lane generator for a 32-bit, 4-lane bus.
//   size_i    : access size code (MEM_BYTE / MEM_HALF / MEM_WORD)
//   addr_lo_i : low two address bits, access is already aligned
//   wd_i      : right-justified store data
//   wstrb_o   : byte enables for the addressed lanes
//   wdata_o   : store data replicated into every lane of its size
// ---------------------------------------------------------------------------
module store_lane_gen
    import mem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wd_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o
);

    // Replicating the data into every lane means the slave can pick up the
    // bytes it needs purely from the strobes, without shifting anything.
    // The unused size code 2'b11 enables no lanes so it can never corrupt memory.
    always_comb begin
        wstrb_o = 4'b0000;
        wdata_o = wd_i;
        case (size_i)
            MEM_BYTE: begin
                wstrb_o = 4'b0001 << addr_lo_i;
                wdata_o = {4{wd_i[7:0]}};
            end
            MEM_HALF: begin
                wstrb_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wd_i[15:0]}};
            end
            MEM_WORD: begin
                wstrb_o = 4'b1111;
                wdata_o = wd_i;
            end
            default: begin
                wstrb_o = 4'b0000;
                wdata_o = wd_i;
            end
        endcase
    end

endmodule

// File: rtl/dmem_sram_bridge.sv
// ---------------------------------------------------------------------------
// dmem_sram_bridge
// Turns each gated MEM-stage load/store into one handshaked transaction on
// the SRAM-like bus, stalls the pipeline until it completes, and keeps the
// load word available while the pipeline stays frozen for other reasons.
//   clk, rst     : clock and synchronous active-high reset
//   memtoregM    : load in MEM (already gated)
//   memwriteM    : store in MEM (already gated)
//   mem_opM      : [1:0] size, [2] unsigned (not needed here)
//   aluoutM      : aligned effective address
//   writedataM   : right-justified store data
//   stall_other  : pipeline frozen by another source this cycle
//   readdataM    : raw aligned load word
//   stallM       : freeze the whole pipeline
//   bus          : request/response bus, master side
// ---------------------------------------------------------------------------
module dmem_sram_bridge
    import mem_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 memtoregM,
    input  logic                 memwriteM,
    input  logic [2:0]           mem_opM,
    input  logic [AW-1:0]        aluoutM,
    input  logic [DW-1:0]        writedataM,
    input  logic                 stall_other,
    output logic [DW-1:0]        readdataM,
    output logic                 stallM,
    dmem_sram_bridge_if.master   bus
);

    db_state_e     state_q, state_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          access;
    logic          completing;
    logic [3:0]    laneStrb;
    logic [DW-1:0] laneWdata;
    logic          unused_opBit;

    assign access       = memtoregM | memwriteM;
    assign unused_opBit = mem_opM[MEM_UNSIGNED_BIT];

    // The response cycle is the only point at which the bridge releases a
    // stalled access; both the stall and the load bypass key off it.
    assign completing = (state_q == DB_DATA) && bus.data_data_ok;

    store_lane_gen u_lanes (
        .size_i    (mem_opM[1:0]),
        .addr_lo_i (aluoutM[1:0]),
        .wd_i      (writedataM),
        .wstrb_o   (laneStrb),
        .wdata_o   (laneWdata)
    );

    // Request fields come straight from the MEM inputs; the pipeline is
    // stalled while a request is pending, so they stay stable until addr_ok.
    assign bus.data_wr    = memwriteM;
    assign bus.data_size  = mem_opM[1:0];
    assign bus.data_addr  = aluoutM;
    assign bus.data_wstrb = memwriteM ? laneStrb : 4'b0000;
    assign bus.data_wdata = laneWdata;

    // Next-state and handshake outputs. HOLD parks a finished access while
    // another stall source keeps the same instruction in MEM, so it is not
    // issued a second time. A data_ok outside DATA is a slave protocol error
    // and is deliberately ignored.
    always_comb begin
        state_d      = state_q;
        rdata_d      = rdata_q;
        bus.data_req = 1'b0;
        stallM       = 1'b0;

        case (state_q)
            DB_IDLE: begin
                bus.data_req = access;
                if (access) begin
                    state_d = bus.data_addr_ok ? DB_DATA : DB_ADDR;
                end
            end
            DB_ADDR: begin
                bus.data_req = 1'b1;
                if (bus.data_addr_ok) begin
                    state_d = DB_DATA;
                end
            end
            DB_DATA: begin
                if (bus.data_data_ok) begin
                    rdata_d = bus.data_rdata;
                    state_d = stall_other ? DB_HOLD : DB_IDLE;
                end
            end
            DB_HOLD: begin
                if (!stall_other) begin
                    state_d = DB_IDLE;
                end
            end
            default: begin
                state_d = DB_IDLE;
            end
        endcase

        stallM = access && (state_q != DB_HOLD) && !completing;
    end

    // The load word is forwarded combinationally in its response cycle and
    // served from the latch afterwards, so a frozen pipeline still sees it.
    assign readdataM = completing ? bus.data_rdata : rdata_q;

    // State and load-data registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DB_IDLE;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

endmodule
